// File: rtl/one_index_iterator.sv
// Walks the set bits of a captured vector one index per handshake, searching
// upward from a rotating start pointer and wrapping at the top bit.
module one_index_iterator #(
    parameter int VECTOR_LENGTH    = 8,
    parameter int MAX_OUTPUT_WIDTH = 16
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic [VECTOR_LENGTH-1:0]    vector_in,
    input  logic [MAX_OUTPUT_WIDTH-1:0] start_index_in,
    input  logic                        vector_valid_in,
    output logic                        vector_ready_out,
    output logic [MAX_OUTPUT_WIDTH-1:0] index_out,
    output logic                        index_valid_out,
    input  logic                        index_ready_in,
    output logic                        last_out,
    output logic [MAX_OUTPUT_WIDTH-1:0] remaining_count_out,
    output logic                        done_out,
    input  logic                        flush_in
);

    localparam int VL = VECTOR_LENGTH;
    localparam int PW = MAX_OUTPUT_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [VL-1:0] vec_q, vec_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          done_q, done_d;

    logic [PW-1:0] idx_sel;
    logic [VL-1:0] sel_mask;
    logic          found;
    logic [PW-1:0] load_pop;
    logic [PW-1:0] load_ptr;

    // First set bit at or above the start pointer, wrapping to bit 0.
    always_comb begin
        int pos;
        found    = 1'b0;
        idx_sel  = '0;
        sel_mask = '0;
        for (int k = 0; k < VL; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= VL) begin
                pos = pos - VL;
            end
            if (!found && vec_q[pos]) begin
                found         = 1'b1;
                idx_sel       = PW'(pos);
                sel_mask[pos] = 1'b1;
            end
        end
    end

    always_comb begin
        load_pop = '0;
        for (int k = 0; k < VL; k++) begin
            load_pop = load_pop + PW'(vector_in[k]);
        end
        load_ptr = (start_index_in >= PW'(VL)) ? '0 : start_index_in;
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (flush_in) begin
            // Abort wins over any load or transfer seen in the same cycle.
            state_d = IDLE;
            vec_d   = '0;
            count_d = '0;
        end else if (state_q == IDLE) begin
            if (vector_valid_in) begin
                vec_d   = vector_in;
                ptr_d   = load_ptr;
                count_d = load_pop;
                if (vector_in != '0) begin
                    state_d = SCAN;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else begin
            if (index_ready_in) begin
                vec_d   = vec_q & ~sel_mask;
                count_d = count_q - PW'(1);
                if (count_q == PW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign vector_ready_out    = (state_q == IDLE);
    assign index_valid_out     = (state_q == SCAN);
    assign index_out           = (state_q == SCAN) ? idx_sel : '0;
    assign last_out            = (state_q == SCAN) && (count_q == PW'(1));
    assign remaining_count_out = count_q;
    assign done_out            = done_q;

endmodule
